// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and defaults for the two-port burst memory arbiter.
//   arb_state_t   : arbiter FSM states (idle, transferring, burst complete)
//   client_t      : identifies one of the two clients
//   DEF_BEATS     : default bytes per burst (one cache line)
//   DEF_TIMEOUT   : default cycles to wait for ready_mem on a single beat
//   client_onehot : converts a client id into a one-hot two-bit vector
package mem_arb_pkg;

    localparam int DEF_BEATS   = 4;
    localparam int DEF_TIMEOUT = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_DONE = 2'd2
    } arb_state_t;

    typedef logic client_t;

    function automatic logic [1:0] client_onehot(input client_t c);
        return c ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/mem_arb_rr.sv
// mem_arb_rr: two-way round-robin selector.
//   req         : legal, eligible requests from client 0 / client 1
//   last_served : client that owned the previous burst
//   sel         : one-hot winner, all-zero when nobody requests
module mem_arb_rr
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  client_t    last_served,
    output logic [1:0] sel
);

    // A lone requester always wins; on a tie the client that was not
    // served last gets the port.
    always_comb begin
        sel = 2'b00;
        if (req == 2'b11) begin
            sel = last_served ? 2'b01 : 2'b10;
        end else begin
            sel = req;
        end
    end

endmodule

// File: rtl/mem_arb_2p.sv
// mem_arb_2p: arbitrates two clients onto one byte-wide memory port, moving
// a whole cache line (BEATS bytes) per grant as a read or write burst.
//   clock, reset            : rising-edge clock, asynchronous active-high reset
//   req_rd, req_wr          : per-client burst read / write requests (level)
//   req_addr0, req_addr1    : per-client line address, bits [1:0] ignored
//   wdata0, wdata1          : per-client write byte for the current beat
//   grant, beat             : one-hot port owner, beat index inside the burst
//   rdata, rvalid           : registered read byte and per-client valid strobe
//   done, err               : per-client burst-complete and error strobes
//   addr_mem, rd_mem, wr_mem, wdata_mem, rdata_mem, ready_mem : memory port
module mem_arb_2p
    import mem_arb_pkg::*;
#(
    parameter int BEATS   = DEF_BEATS,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  req_rd,
    input  logic [1:0]  req_wr,
    input  logic [15:0] req_addr0,
    input  logic [15:0] req_addr1,
    input  logic [7:0]  wdata0,
    input  logic [7:0]  wdata1,
    output logic [1:0]  grant,
    output logic [1:0]  beat,
    output logic [7:0]  rdata,
    output logic [1:0]  rvalid,
    output logic [1:0]  done,
    output logic [1:0]  err,
    output logic [15:0] addr_mem,
    output logic        rd_mem,
    output logic        wr_mem,
    output logic [7:0]  wdata_mem,
    input  logic [7:0]  rdata_mem,
    input  logic        ready_mem
);

    localparam int            TW        = $clog2(TIMEOUT + 1);
    localparam logic [1:0]    LAST_BEAT = 2'(BEATS - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);

    arb_state_t    state_q, state_d;
    client_t       owner_q, owner_d;
    client_t       last_q, last_d;
    logic [13:0]   line_q, line_d;
    logic          dir_wr_q, dir_wr_d;
    logic [1:0]    beat_q, beat_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [1:0]    grant_q, grant_d;
    logic [7:0]    rdata_q, rdata_d;
    logic [1:0]    rvalid_q, rvalid_d;
    logic [1:0]    done_q, done_d;
    logic [1:0]    err_q, err_d;
    logic [1:0]    illegal_q;
    logic          armed_q;

    logic [1:0]    illegal;
    logic [1:0]    legal;
    logic [1:0]    rr_sel;
    logic          unused_addr_bits;

    assign unused_addr_bits = ^{req_addr0[1:0], req_addr1[1:0]};

    // A client asking for read and write at once is illegal and never
    // eligible. Arbitration is also held off for the first edge after reset
    // so the earliest grant lands on the second edge.
    assign illegal = req_rd & req_wr;
    assign legal   = (req_rd ^ req_wr) & {2{armed_q}};

    mem_arb_rr u_rr (
        .req         (legal),
        .last_served (last_q),
        .sel         (rr_sel)
    );

    // Register bank: every piece of arbiter state, including the FSM state,
    // clears asynchronously so a mid-burst reset drops the port immediately.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            owner_q   <= 1'b0;
            last_q    <= 1'b1;
            line_q    <= '0;
            dir_wr_q  <= 1'b0;
            beat_q    <= '0;
            tmo_q     <= '0;
            grant_q   <= '0;
            rdata_q   <= '0;
            rvalid_q  <= '0;
            done_q    <= '0;
            err_q     <= '0;
            illegal_q <= '0;
            armed_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            line_q    <= line_d;
            dir_wr_q  <= dir_wr_d;
            beat_q    <= beat_d;
            tmo_q     <= tmo_d;
            grant_q   <= grant_d;
            rdata_q   <= rdata_d;
            rvalid_q  <= rvalid_d;
            done_q    <= done_d;
            err_q     <= err_d;
            illegal_q <= illegal;
            armed_q   <= 1'b1;
        end
    end

    // Next-state logic. An illegal request raises err once, on the cycle it
    // first appears, rather than every cycle it is held. In XFER each beat
    // waits for ready_mem; a long enough run of not-ready cycles abandons the
    // burst straight back to IDLE without a done pulse.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        last_d   = last_q;
        line_d   = line_q;
        dir_wr_d = dir_wr_q;
        beat_d   = beat_q;
        tmo_d    = tmo_q;
        grant_d  = grant_q;
        rdata_d  = rdata_q;
        rvalid_d = '0;
        done_d   = '0;
        err_d    = illegal & ~illegal_q;

        case (state_q)
            ST_IDLE: begin
                grant_d = '0;
                if (|rr_sel) begin
                    state_d  = ST_XFER;
                    owner_d  = rr_sel[1];
                    last_d   = rr_sel[1];
                    grant_d  = rr_sel;
                    line_d   = rr_sel[1] ? req_addr1[15:2] : req_addr0[15:2];
                    dir_wr_d = rr_sel[1] ? req_wr[1] : req_wr[0];
                    beat_d   = '0;
                    tmo_d    = '0;
                end
            end
            ST_XFER: begin
                if (ready_mem) begin
                    tmo_d = '0;
                    if (!dir_wr_q) begin
                        rdata_d  = rdata_mem;
                        rvalid_d = client_onehot(owner_q);
                    end
                    if (beat_q == LAST_BEAT) begin
                        beat_d  = '0;
                        state_d = ST_DONE;
                        done_d  = client_onehot(owner_q);
                    end else begin
                        beat_d = 2'(beat_q + 2'd1);
                    end
                end else if (tmo_q == TMO_LAST) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    beat_d  = '0;
                    tmo_d   = '0;
                    err_d   = err_d | client_onehot(owner_q);
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // Memory-side strobes follow the state directly so they fall the same
    // cycle the burst ends or is aborted.
    always_comb begin
        rd_mem    = (state_q == ST_XFER) && !dir_wr_q;
        wr_mem    = (state_q == ST_XFER) && dir_wr_q;
        wdata_mem = owner_q ? wdata1 : wdata0;
        addr_mem  = {line_q, beat_q};
    end

    assign grant  = grant_q;
    assign beat   = beat_q;
    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;
    assign done   = done_q;
    assign err    = err_q;

endmodule

// File: tb/tb_mem_arb_2p.sv
// tb_mem_arb_2p: directed self-checking bench for mem_arb_2p. Inputs change
// and outputs are sampled 1 ns after each rising edge.
module tb_mem_arb_2p;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  req_rd, req_wr;
    logic [15:0] req_addr0, req_addr1;
    logic [7:0]  wdata0, wdata1;
    logic [1:0]  grant, beat, rvalid, done, err;
    logic [7:0]  rdata, wdata_mem, rdata_mem;
    logic [15:0] addr_mem;
    logic        rd_mem, wr_mem, ready_mem;

    logic [7:0]  mem_data [4];
    int          pass_cnt = 0;
    int          check_cnt = 0;
    int          n_seen;

    mem_arb_2p dut (
        .clock     (clock),
        .reset     (reset),
        .req_rd    (req_rd),
        .req_wr    (req_wr),
        .req_addr0 (req_addr0),
        .req_addr1 (req_addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .grant     (grant),
        .beat      (beat),
        .rdata     (rdata),
        .rvalid    (rvalid),
        .done      (done),
        .err       (err),
        .addr_mem  (addr_mem),
        .rd_mem    (rd_mem),
        .wr_mem    (wr_mem),
        .wdata_mem (wdata_mem),
        .rdata_mem (rdata_mem),
        .ready_mem (ready_mem)
    );

    always #5 clock = ~clock;

    // Simple line memory: returns the byte for the beat being addressed.
    assign rdata_mem = mem_data[addr_mem[1:0]];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] rd, input logic [1:0] wr,
                                 input logic [15:0] a0, input logic [15:0] a1);
        req_rd    = rd;
        req_wr    = wr;
        req_addr0 = a0;
        req_addr1 = a1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        check_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic applyReset();
        reset = 1'b1;
        applyStimulus(2'b00, 2'b00, 16'h0000, 16'h0000);
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Watchdog so a stuck run still terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        mem_data[0] = 8'h11;
        mem_data[1] = 8'h22;
        mem_data[2] = 8'h33;
        mem_data[3] = 8'h44;
        wdata0    = 8'h00;
        wdata1    = 8'h00;
        ready_mem = 1'b0;
        reset     = 1'b1;
        applyStimulus(2'b00, 2'b00, 16'h0000, 16'h0000);
        tick();
        tick();

        $display("[TB] reset state");
        checkOutput("rst_grant", 32'(grant), 32'h0);
        checkOutput("rst_beat", 32'(beat), 32'h0);
        checkOutput("rst_addr", 32'(addr_mem), 32'h0);
        checkOutput("rst_rdata", 32'(rdata), 32'h0);
        checkOutput("rst_strobes", 32'({rvalid, done, err, rd_mem, wr_mem}), 32'h0);

        $display("[TB] single read burst, client 0 at C08B");
        reset = 1'b0;
        ready_mem = 1'b1;
        applyStimulus(2'b01, 2'b00, 16'hC08B, 16'h0000);
        tick();
        checkOutput("first_edge_no_grant", 32'(grant), 32'h0);
        tick();
        checkOutput("rd_grant", 32'(grant), 32'h1);
        checkOutput("rd_rd_mem", 32'(rd_mem), 32'h1);
        checkOutput("rd_addr_b0", 32'(addr_mem), 32'hC088);
        for (int i = 0; i < 4; i++) begin
            if (i == 1) req_addr0 = 16'hBEEF;
            tick();
            checkOutput("rd_rvalid", 32'(rvalid), 32'h1);
            checkOutput("rd_rdata", 32'(rdata), 32'(mem_data[i]));
            if (i < 3) begin
                checkOutput("rd_addr", 32'(addr_mem), 32'hC088 + 32'(i + 1));
                checkOutput("rd_beat", 32'(beat), 32'(i + 1));
            end
        end
        checkOutput("rd_done", 32'(done), 32'h1);
        checkOutput("rd_done_grant_held", 32'(grant), 32'h1);
        checkOutput("rd_done_strobe_low", 32'(rd_mem), 32'h0);
        req_rd = 2'b00;
        tick();
        checkOutput("rd_idle_grant", 32'(grant), 32'h0);
        checkOutput("rd_idle_done", 32'(done), 32'h0);

        $display("[TB] simultaneous requests after reset");
        applyReset();
        applyStimulus(2'b01, 2'b10, 16'h1000, 16'h2004);
        tick();
        tick();
        checkOutput("both_first_c0", 32'(grant), 32'h1);
        tick();
        tick();
        tick();
        tick();
        checkOutput("both_c0_done", 32'(done), 32'h1);
        req_rd = 2'b00;
        tick();
        checkOutput("both_bubble", 32'(grant), 32'h0);
        tick();
        checkOutput("both_second_c1", 32'(grant), 32'h2);
        checkOutput("both_rd_mem_low", 32'(rd_mem), 32'h0);
        for (int i = 0; i < 4; i++) begin
            wdata1 = 8'hA0 + 8'(i);
            #1;
            checkOutput("wr_wdata_mem", 32'(wdata_mem), 32'hA0 + 32'(i));
            checkOutput("wr_addr", 32'(addr_mem), 32'h2004 + 32'(i));
            checkOutput("wr_wr_mem", 32'(wr_mem), 32'h1);
            checkOutput("wr_no_rvalid", 32'(rvalid), 32'h0);
            tick();
        end
        checkOutput("wr_done", 32'(done), 32'h2);
        checkOutput("wr_done_wr_low", 32'(wr_mem), 32'h0);
        req_wr = 2'b00;
        tick();
        checkOutput("wr_idle_grant", 32'(grant), 32'h0);

        $display("[TB] stall on beat 2");
        applyStimulus(2'b01, 2'b00, 16'h3000, 16'h0000);
        tick();
        checkOutput("stall_grant", 32'(grant), 32'h1);
        tick();
        tick();
        ready_mem = 1'b0;
        checkOutput("stall_addr_c1", 32'(addr_mem), 32'h3002);
        for (int k = 2; k <= 4; k++) begin
            tick();
            checkOutput("stall_addr_held", 32'(addr_mem), 32'h3002);
            checkOutput("stall_no_rvalid", 32'(rvalid), 32'h0);
            checkOutput("stall_rd_mem", 32'(rd_mem), 32'h1);
        end
        ready_mem = 1'b1;
        tick();
        checkOutput("stall_b2_data", 32'(rdata), 32'h33);
        checkOutput("stall_addr_b3", 32'(addr_mem), 32'h3003);
        tick();
        checkOutput("stall_done", 32'(done), 32'h1);
        checkOutput("stall_b3_data", 32'(rdata), 32'h44);
        req_rd = 2'b00;
        tick();

        $display("[TB] memory never ready");
        ready_mem = 1'b0;
        applyStimulus(2'b00, 2'b01, 16'h4000, 16'h0000);
        tick();
        checkOutput("tmo_grant", 32'(grant), 32'h1);
        checkOutput("tmo_wr_mem", 32'(wr_mem), 32'h1);
        n_seen = 80;
        for (int n = 1; n <= 80; n++) begin
            tick();
            if (err != 2'b00) begin
                n_seen = n;
                break;
            end
        end
        checkOutput("tmo_cycles", 32'(n_seen), 32'd64);
        checkOutput("tmo_err", 32'(err), 32'h1);
        checkOutput("tmo_no_done", 32'(done), 32'h0);
        checkOutput("tmo_grant_released", 32'(grant), 32'h0);
        checkOutput("tmo_wr_low", 32'(wr_mem), 32'h0);
        req_wr = 2'b00;
        tick();
        checkOutput("tmo_err_single", 32'(err), 32'h0);

        $display("[TB] reset during beat 1");
        ready_mem = 1'b1;
        applyStimulus(2'b11, 2'b00, 16'h5000, 16'h7000);
        tick();
        checkOutput("rr_alternate_c1", 32'(grant), 32'h2);
        checkOutput("rr_c1_addr", 32'(addr_mem), 32'h7000);
        tick();
        checkOutput("mid_beat1", 32'(beat), 32'h1);
        reset = 1'b1;
        #1;
        checkOutput("mid_rst_grant", 32'(grant), 32'h0);
        checkOutput("mid_rst_addr", 32'(addr_mem), 32'h0);
        checkOutput("mid_rst_rdata", 32'(rdata), 32'h0);
        checkOutput("mid_rst_misc", 32'({beat, rvalid, done, err, rd_mem, wr_mem}), 32'h0);
        tick();
        reset = 1'b0;
        tick();
        checkOutput("post_rst_wait", 32'(grant), 32'h0);
        tick();
        checkOutput("post_rst_c0_pref", 32'(grant), 32'h1);
        checkOutput("post_rst_addr", 32'(addr_mem), 32'h5000);

        $display("[TB] illegal request from client 0");
        applyReset();
        applyStimulus(2'b11, 2'b01, 16'h5000, 16'h6000);
        tick();
        checkOutput("illegal_err0", 32'(err), 32'h1);
        checkOutput("illegal_no_grant", 32'(grant), 32'h0);
        tick();
        checkOutput("illegal_err_pulse", 32'(err), 32'h0);
        checkOutput("illegal_c1_granted", 32'(grant), 32'h2);
        checkOutput("illegal_c1_addr", 32'(addr_mem), 32'h6000);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/mem_arb_2p.md
MEM_ARB_2P -- requirements
Module: mem_arb_2p

Interface
REQ-001 Parameter BEATS, default 4, meaning bytes per burst (one cache line).
REQ-002 Parameter TIMEOUT, default 64, meaning max cycles waited for ready_mem per beat.
REQ-003 clock  input  1  single clock, all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req_rd[1:0]  input  2  per-client burst read (line fill) request, level, held until done.
REQ-006 req_wr[1:0]  input  2  per-client burst write (write-back) request, level, held until done.
REQ-007 req_addr0, req_addr1  input  16 each  per-client line address; bits [1:0] ignored.
REQ-008 wdata0, wdata1  input  8 each  per-client write byte for the current beat.
REQ-009 grant[1:0]  output  2  one-hot owner of the memory port, all-zero when idle.
REQ-010 beat  output  2  index of current beat within burst.
REQ-011 rdata  output  8  read byte forwarded from rdata_mem.
REQ-012 rvalid[1:0]  output  2  one-cycle per-client strobe: rdata valid for this beat.
REQ-013 done[1:0]  output  2  one-cycle per-client strobe: burst complete.
REQ-014 err[1:0]  output  2  one-cycle per-client strobe: illegal request or timeout.
REQ-015 addr_mem  output  16  memory address, {line[15:2], beat}.
REQ-016 rd_mem, wr_mem  output  1 each  memory strobes, never both high.
REQ-017 wdata_mem  output  8  granted client's wdata.
REQ-018 rdata_mem  input  8  memory read data, valid with ready_mem.
REQ-019 ready_mem  input  1  memory completes current beat when high at a rising edge.

Function
REQ-020 States IDLE, XFER, DONE; IDLE->XFER on any legal request, XFER->DONE after beat BEATS-1 completes, DONE->IDLE unconditionally.
REQ-021 Request seen in IDLE at edge N -> grant, addr_mem, rd_mem/wr_mem valid from edge N+1 (one-cycle latency).
REQ-022 Round-robin: when both clients request, grant the client not served last; after reset client 0 wins.
REQ-023 Line address and direction latched at grant; client changes to req_addr during XFER ignored.
REQ-024 Each beat: strobe and addr_mem held until ready_mem high at an edge; then beat increments (wraps 3->0 only at burst end).
REQ-025 Read beat: rdata registered from rdata_mem and rvalid[owner] pulsed on the cycle after the completing edge.
REQ-026 Write beat: wdata_mem combinationally equals wdata of the owner; wr_mem high through all beats.
REQ-027 DONE: strobes low, done[owner] pulsed, grant still held; grant drops entering IDLE; next arbitration no earlier than IDLE cycle (one bubble cycle between bursts).
REQ-028 req_rd and req_wr both high for a client: illegal, err pulsed for that client, request not granted while illegal; other client arbitrated normally.
REQ-029 ready_mem low for TIMEOUT consecutive cycles in a beat: abort burst, strobes low, err[owner] pulsed, go to IDLE, no done.
REQ-030 Client dropping its request mid-burst does not abort; burst completes.
REQ-031 ready_mem outside XFER ignored.

Reset
REQ-032 reset asserted at any time forces IDLE, grant=0, beat=0, all strobes/pulses 0, addr_mem=0, rdata=0, RR pointer to client 0, timeout counter 0, including mid-burst.
REQ-033 First grant possible at the second rising edge after reset deasserts.

Structure
REQ-034 Package mem_arb_pkg holds state enum, BEATS/TIMEOUT defaults, client-id type.
REQ-035 Round-robin selection in sub-module mem_arb_rr (requests + last-served in, one-hot grant out).

Verification
REQ-036 Client 0 reads 0xC08B, memory ready every cycle, data 11,22,33,44 -> addr_mem C088..C08B, rvalid0 four times with 11..44, done0 once.
REQ-037 Both clients request same cycle (0 read 0x1000, 1 write 0x2004) -> client 0 served first, then client 1 with bubble; second burst wr_mem, addr 2004..2007.
REQ-038 Ready_mem stalls 3 cycles on beat 2 -> addr_mem held at beat 2 for 4 cycles, burst completes correctly.
REQ-039 Ready_mem never asserted -> err pulse after 64 cycles, no done, grant released.
REQ-040 reset pulsed during beat 1 -> all outputs 0 immediately; after release client 0 preferred.
REQ-041 req_rd0 and req_wr0 both high with client 1 requesting -> err0 pulses, client 1 granted.
